lamp_guard: RTL and testbench

LAMP_GUARD -- requirements
Module: lamp_guard

---
 rtl/lamp_pkg.sv | 15 +
 rtl/lamp_flash_gen.sv | 41 ++++
 rtl/lamp_guard.sv | 122 ++++++++++++
 tb/tb_lamp_guard.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lamp_pkg.sv
// Shared lamp codes and guard state encoding for the lamp_guard block.
package lamp_pkg;

   localparam logic [0:2] RED      = 3'b100;
   localparam logic [0:2] GREEN    = 3'b010;
   localparam logic [0:2] YELLOW   = 3'b001;
   localparam logic [0:2] LAMP_OFF = 3'b000;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } guard_state_e;

endpackage

// File: rtl/lamp_flash_gen.sv
// Fault flash timer: phase is 0 for FLASH_HALF cycles, then 1 for FLASH_HALF cycles, while enabled.
module lamp_flash_gen #(
   parameter int FLASH_HALF = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   output logic phase
);

   logic [7:0] cnt_q, cnt_d;
   logic       phase_q, phase_d;

   // Dropping enable rearms the timer so every fault entry starts in phase 0.
   always_comb begin
      cnt_d   = 8'd0;
      phase_d = 1'b0;
      if (enable) begin
         if (cnt_q == 8'(FLASH_HALF - 1)) begin
            cnt_d   = 8'd0;
            phase_d = ~phase_q;
         end else begin
            cnt_d   = cnt_q + 8'd1;
            phase_d = phase_q;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= 8'd0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/lamp_guard.sv
// Lamp sequence guard: passes the sequencer's lamp code through one register and traps illegal codes/changes/dwell.
// Define LAMP_GUARD_FLASH_EN for a flashing yellow fault lamp; otherwise the fault lamp is steady red.
module lamp_guard
   import lamp_pkg::*;
#(
   parameter int MAX_DWELL  = 4,
   parameter int FLASH_HALF = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [0:2] light_in,
   input  logic       clear,
   output logic [0:2] light_out,
   output logic       fault,
   output logic [7:0] err_count
);

   if (MAX_DWELL < 1 || MAX_DWELL > 255 || FLASH_HALF < 1 || FLASH_HALF > 255) begin : g_param_check
      $error("lamp_guard: MAX_DWELL and FLASH_HALF must be in 1..255");
   end

   guard_state_e state_q, state_d;
   logic [0:2]   last_in_q, last_in_d;
   logic [7:0]   dwell_q, dwell_d;
   logic [7:0]   err_count_q, err_count_d;
   logic [0:2]   fault_lamp;
   logic         code_ok, same, step_ok, trip;

`ifdef LAMP_GUARD_FLASH_EN
   logic flash_phase;

   lamp_flash_gen #(
      .FLASH_HALF (FLASH_HALF)
   ) u_flash (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (state_q == FAULT),
      .phase   (flash_phase)
   );

   assign fault_lamp = flash_phase ? LAMP_OFF : YELLOW;
`else
   assign fault_lamp = RED;
`endif

   // All fault causes collapse into one trip flag so a cycle records a single entry.
   always_comb begin
      code_ok = (light_in == RED) || (light_in == GREEN) || (light_in == YELLOW);
      same    = (light_in == last_in_q);
      step_ok = ((last_in_q == GREEN)  && (light_in == YELLOW)) ||
                ((last_in_q == YELLOW) && (light_in == RED))    ||
                ((last_in_q == RED)    && (light_in == GREEN));
      trip    = !code_ok || (!same && !step_ok) || (same && (dwell_q >= 8'(MAX_DWELL)));
   end

   always_comb begin
      state_d     = state_q;
      last_in_d   = last_in_q;
      dwell_d     = dwell_q;
      err_count_d = err_count_q;
      case (state_q)
         INIT: begin
            dwell_d = 8'd0;
            if (light_in == RED) begin
               state_d   = TRACK;
               last_in_d = RED;
               dwell_d   = 8'd1;
            end
         end
         TRACK: begin
            if (trip) begin
               state_d = FAULT;
               dwell_d = 8'd0;
               if (err_count_q != 8'hFF) begin
                  err_count_d = err_count_q + 8'd1;
               end
            end else begin
               last_in_d = light_in;
               dwell_d   = same ? dwell_q + 8'd1 : 8'd1;
            end
         end
         FAULT: begin
            dwell_d = 8'd0;
            if (clear) begin
               state_d = INIT;
            end
         end
         default: begin
            state_d = INIT;
            dwell_d = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= INIT;
         last_in_q   <= RED;
         dwell_q     <= 8'd0;
         err_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         last_in_q   <= last_in_d;
         dwell_q     <= dwell_d;
         err_count_q <= err_count_d;
      end
   end

   // Output decode is purely from registered state, so reset takes effect without a clock.
   always_comb begin
      light_out = RED;
      case (state_q)
         TRACK:   light_out = last_in_q;
         FAULT:   light_out = fault_lamp;
         default: light_out = RED;
      endcase
   end

   assign fault     = (state_q == FAULT);
   assign err_count = err_count_q;

endmodule

// File: tb/tb_lamp_guard.sv
// Directed and randomized checks of lamp_guard against a run-length/history reference model.
module tb_lamp_guard;

   localparam int MAX_DWELL  = 4;
   localparam int FLASH_HALF = 4;

   localparam logic [0:2] C_RED    = 3'b100;
   localparam logic [0:2] C_GREEN  = 3'b010;
   localparam logic [0:2] C_YELLOW = 3'b001;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [0:2] light_in;
   logic       clear;
   logic [0:2] light_out;
   logic       fault;
   logic [7:0] err_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: 0 = waiting for red, 1 = following, 2 = trapped
   int         m_mode;
   logic [0:2] m_prev;
   int         m_run;
   int         m_age;
   int         m_err;
   logic [0:2] cur;

   lamp_guard #(
      .MAX_DWELL  (MAX_DWELL),
      .FLASH_HALF (FLASH_HALF)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .light_in  (light_in),
      .clear     (clear),
      .light_out (light_out),
      .fault     (fault),
      .err_count (err_count)
   );

   always #5 clock = ~clock;

   function automatic logic [0:2] succ(input logic [0:2] c);
      logic [0:2] ring [3];
      ring[0] = C_RED;
      ring[1] = C_GREEN;
      ring[2] = C_YELLOW;
      for (int i = 0; i < 3; i++) begin
         if (ring[i] == c) return ring[(i + 1) % 3];
      end
      return 3'b111;
   endfunction

   function automatic bit is_colour(input logic [0:2] c);
      return (c == C_RED) || (c == C_GREEN) || (c == C_YELLOW);
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_prev = C_RED;
      m_run  = 0;
      m_age  = 0;
      m_err  = 0;
   endtask

   task automatic model_edge(input logic [0:2] in, input logic clr);
      case (m_mode)
         0: if (in == C_RED) begin
            m_mode = 1;
            m_prev = in;
            m_run  = 1;
         end
         1: begin
            if (!is_colour(in) || (in != m_prev && in != succ(m_prev)) ||
                (in == m_prev && m_run + 1 > MAX_DWELL)) begin
               m_mode = 2;
               m_age  = 0;
               m_err  = (m_err < 255) ? m_err + 1 : 255;
            end else begin
               m_run  = (in == m_prev) ? m_run + 1 : 1;
               m_prev = in;
            end
         end
         default: if (clr) m_mode = 0; else m_age++;
      endcase
   endtask

   function automatic logic [0:2] exp_lamp();
      if (m_mode == 0) return C_RED;
      if (m_mode == 1) return m_prev;
`ifdef LAMP_GUARD_FLASH_EN
      return (((m_age / FLASH_HALF) % 2) == 1) ? 3'b000 : C_YELLOW;
`else
      return C_RED;
`endif
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".light_out"}, {5'b0, light_out}, {5'b0, exp_lamp()});
      check({tag, ".fault"}, {7'b0, fault}, {7'b0, (m_mode == 2)});
      check({tag, ".err_count"}, err_count, 8'(m_err));
   endtask

   task automatic step(input string tag, input logic [0:2] in, input logic clr);
      light_in = in;
      clear    = clr;
      @(posedge clock);
      model_edge(in, clr);
      #1;
      check_all(tag);
   endtask

   initial begin
      reset_n  = 1'b0;
      light_in = C_GREEN;
      clear    = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      @(posedge clock);
      #1;
      check_all("reset_held");
      #3 reset_n = 1'b1;

      // Legal stream passes through delayed by one cycle
      step("s_red",    C_RED,    1'b0);
      step("s_green",  C_GREEN,  1'b0);
      step("s_yellow", C_YELLOW, 1'b0);
      step("s_red2",   C_RED,    1'b0);
      step("s_green2", C_GREEN,  1'b0);

      // Red then yellow is an illegal change; watch the fault lamp pattern
      step("ry_yellow", C_YELLOW, 1'b0);
      step("ry_red",    C_RED,    1'b0);
      step("ry_bad",    C_YELLOW, 1'b0);
      for (int i = 0; i < 10; i++) step("ry_hold", 3'($urandom_range(0, 7)), 1'b0);
      step("ry_clear", C_GREEN, 1'b1);

      // Dwell overrun on the fifth green sample
      step("dw_red", C_RED, 1'b0);
      for (int i = 0; i < 5; i++) step("dw_green", C_GREEN, 1'b0);
      step("dw_clear", C_RED, 1'b1);

      // Fault beats a simultaneous clear
      step("cf_red", C_RED, 1'b0);
      step("cf_bad", 3'b011, 1'b1);
      step("cf_hold", C_RED, 1'b0);
      step("cf_clear", C_GREEN, 1'b1);
      step("cf_init", C_GREEN, 1'b0);

      // Randomized, biased toward legal sequencing so tracking gets exercised
      cur = C_RED;
      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 3) cur = cur;
         else if (r < 8) cur = is_colour(cur) ? succ(cur) : C_RED;
         else cur = 3'($urandom_range(0, 7));
         step("rand", cur, ($urandom_range(0, 3) == 0));
      end

      // Counter saturation across many fault/clear rounds
      for (int i = 0; i < 300; i++) begin
         step("sat_red", C_RED, 1'b0);
         step("sat_bad", 3'b000, 1'b0);
         step("sat_clr", C_RED, 1'b1);
      end
      check("sat_final", err_count, 8'd255);

      // Asynchronous reset in the middle of a fault
      step("ar_red", C_RED, 1'b0);
      step("ar_bad", 3'b111, 1'b0);
      step("ar_hold", C_RED, 1'b0);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      check_all("async_reset");
      #2 reset_n = 1'b1;
      step("ar_resume_red", C_RED, 1'b0);
      step("ar_resume_green", C_GREEN, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
